// File: rtl/vector_ocp_slave_if.sv
// rtl/vector_ocp_slave_if.sv - OCP-style command/response bundle for the vector slave
interface vector_ocp_slave_if #(
  parameter int VW = 128
) ();
  logic [2:0]      MCmd;
  logic [31:0]     MAddr;
  logic [VW-1:0]   MData;
  logic [VW/8-1:0] MByteEn;
  logic            SCmdAccept;
  logic [1:0]      SResp;
  logic [VW-1:0]   SData;
  logic            MRespAccept;

  modport master (
    output MCmd, MAddr, MData, MByteEn, MRespAccept,
    input  SCmdAccept, SResp, SData
  );

  modport slave (
    input  MCmd, MAddr, MData, MByteEn, MRespAccept,
    output SCmdAccept, SResp, SData
  );
endinterface

// File: rtl/vector_ocp_slave.sv
// rtl/vector_ocp_slave.sv - single-outstanding OCP slave over a byte-maskable vector store
module vector_ocp_slave #(
  parameter int ELEM_SIZE  = 16,
  parameter int NUM_ELEMS  = 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic              clk,
  input  logic              reset,
  vector_ocp_slave_if.slave bus
);
  localparam int VW    = ELEM_SIZE * NUM_ELEMS;
  localparam int BE    = VW / 8;
  localparam int OFS   = $clog2(BE);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_WR    = 3'd1;
  localparam logic [2:0] CMD_RD    = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t                state, state_next;
  logic [VW-1:0]         mem [DEPTH];
  logic [VW-1:0]         resp_data;
  logic [1:0]            resp_code;
  logic                  accept, do_wr, do_rd;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;

  assign idx      = bus.MAddr[OFS +: DEPTH_LOG2];
  assign in_range = (bus.MAddr >> (OFS + DEPTH_LOG2)) == '0;

  // Reset gates accept directly so nothing is taken while reset is held low.
  always_comb begin
    accept     = 1'b0;
    state_next = state;
    if (reset && (bus.MCmd != CMD_IDLE) &&
        ((state == S_IDLE) || bus.MRespAccept)) begin
      accept = 1'b1;
    end
    if (accept) begin
      state_next = S_RESP;
    end else if ((state == S_RESP) && bus.MRespAccept) begin
      state_next = S_IDLE;
    end
    do_wr = accept && (bus.MCmd == CMD_WR) && in_range;
    do_rd = accept && (bus.MCmd == CMD_RD) && in_range;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_code <= RESP_NULL;
      resp_data <= '0;
    end else if (accept) begin
      if (do_rd) begin
        resp_code <= RESP_DVA;
        resp_data <= mem[idx];
      end else if (do_wr) begin
        resp_code <= RESP_DVA;
        resp_data <= '0;
      end else begin
        resp_code <= RESP_ERR;
        resp_data <= '0;
      end
    end
  end

  // Storage is deliberately left out of reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < BE; i++) begin
        if (bus.MByteEn[i]) begin
          mem[idx][i*8 +: 8] <= bus.MData[i*8 +: 8];
        end
      end
    end
  end

  assign bus.SCmdAccept = accept;
  assign bus.SResp      = (state == S_RESP) ? resp_code : RESP_NULL;
  assign bus.SData      = (state == S_RESP) ? resp_data : '0;
endmodule

// File: tb/tb_vector_ocp_slave.sv
// tb/tb_vector_ocp_slave.sv - randomized self-checking bench for vector_ocp_slave
module tb_vector_ocp_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_ocp_slave_if #(.VW(128)) bus ();

  vector_ocp_slave #(.ELEM_SIZE(16), .NUM_ELEMS(8), .DEPTH_LOG2(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  localparam logic [127:0] D30  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] ONES = {128{1'b1}};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: byte array with per-byte "known" flags and one pending response slot.
  logic [127:0] m_mem   [256];
  logic [15:0]  m_valid [256];
  logic         m_pending = 1'b0;
  logic [1:0]   m_resp;
  logic [127:0] m_data, m_dmask;

  logic         s_acc, e_acc;
  logic [1:0]   s_resp, e_resp;
  logic [127:0] s_data, e_data, e_mask;

  function automatic logic [127:0] expand(input logic [15:0] be);
    logic [127:0] m;
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic cycle(input logic [2:0] cmd, input logic [31:0] addr,
                       input logic [127:0] data, input logic [15:0] be, input logic racc);
    logic       inr;
    logic [7:0] ix;
    logic [127:0] bm;
    bus.MCmd = cmd; bus.MAddr = addr; bus.MData = data;
    bus.MByteEn = be; bus.MRespAccept = racc;
    @(negedge clk);
    s_acc  = bus.SCmdAccept;
    s_resp = bus.SResp;
    s_data = bus.SData;
    e_acc  = rst_n && (cmd != 3'd0) && (!m_pending || racc);
    e_resp = m_pending ? m_resp : 2'd0;
    e_data = m_pending ? m_data : '0;
    e_mask = m_pending ? m_dmask : ONES;
    @(posedge clk);
    inr = (addr[31:12] == 20'h0);
    ix  = addr[11:4];
    if (m_pending && racc) m_pending = 1'b0;
    if (e_acc) begin
      m_pending = 1'b1;
      m_resp    = 2'd1;
      m_data    = '0;
      m_dmask   = ONES;
      if (cmd == 3'd2 && inr) begin
        m_data  = m_mem[ix];
        m_dmask = expand(m_valid[ix]);
      end else if (cmd == 3'd1 && inr) begin
        bm          = expand(be);
        m_mem[ix]   = (m_mem[ix] & ~bm) | (data & bm);
        m_valid[ix] = m_valid[ix] | be;
      end else begin
        m_resp = 2'd3;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.MCmd = 3'd1; bus.MAddr = 32'h20; bus.MData = ONES;
    bus.MByteEn = 16'hFFFF; bus.MRespAccept = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.SCmdAccept !== 1'b0) begin
      n_errors++; $display("FAIL reset_accept: got %b expected 0", bus.SCmdAccept);
    end
    n_checks++;
    if (bus.SResp !== 2'd0) begin
      n_errors++; $display("FAIL reset_resp: got %0d expected 0", bus.SResp);
    end
    n_checks++;
    if (bus.SData !== '0) begin
      n_errors++; $display("FAIL reset_data: got %h expected 0", bus.SData);
    end
    bus.MCmd = 3'd0;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    cycle(3'd1, 32'h20, D30, 16'hFFFF, 1'b1);
    n_checks++;
    if (s_acc !== 1'b1) begin
      n_errors++; $display("FAIL wr_accept: got %b expected 1", s_acc);
    end
    cycle(3'd2, 32'h20, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_resp !== 2'd1 || s_data !== '0) begin
      n_errors++; $display("FAIL wr_resp: got %0d/%h expected 1/0", s_resp, s_data);
    end
    cycle(3'd0, 32'h0, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_resp !== 2'd1 || s_data !== D30) begin
      n_errors++; $display("FAIL rd_data: got %0d/%h expected 1/%h", s_resp, s_data, D30);
    end
  endtask

  task automatic test_byte_enable;
    cycle(3'd1, 32'h20, '0, 16'hFFFF, 1'b1);
    cycle(3'd1, 32'h20, ONES, 16'h0001, 1'b1);
    cycle(3'd2, 32'h20, '0, 16'h0, 1'b1);
    cycle(3'd0, 32'h0, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_data !== 128'hFF) begin
      n_errors++; $display("FAIL byte_enable: got %h expected ff", s_data);
    end
  endtask

  task automatic test_out_of_range;
    cycle(3'd2, 32'h1000, '0, 16'h0, 1'b1);
    cycle(3'd3, 32'h20, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_resp !== 2'd3 || s_data !== '0) begin
      n_errors++; $display("FAIL oor_read: got %0d/%h expected 3/0", s_resp, s_data);
    end
    cycle(3'd1, 32'h1020, ONES, 16'hFFFF, 1'b1);
    n_checks++;
    if (s_resp !== 2'd3) begin
      n_errors++; $display("FAIL unsupported_cmd: got %0d expected 3", s_resp);
    end
    cycle(3'd2, 32'h20, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_resp !== 2'd3) begin
      n_errors++; $display("FAIL oor_write_resp: got %0d expected 3", s_resp);
    end
    cycle(3'd0, 32'h0, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_data !== 128'hFF) begin
      n_errors++; $display("FAIL oor_storage: got %h expected ff", s_data);
    end
  endtask

  task automatic test_backpressure;
    cycle(3'd2, 32'h20, '0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(3'd1, 32'h20, D30, 16'hFFFF, 1'b0);
      n_checks++;
      if (s_acc !== 1'b0 || s_resp !== 2'd1 || s_data !== 128'hFF) begin
        n_errors++;
        $display("FAIL stall_hold: got acc=%b resp=%0d data=%h expected 0/1/ff", s_acc, s_resp, s_data);
      end
    end
    cycle(3'd1, 32'h20, D30, 16'hFFFF, 1'b1);
    n_checks++;
    if (s_acc !== 1'b1) begin
      n_errors++; $display("FAIL stall_release: got %b expected 1", s_acc);
    end
    cycle(3'd2, 32'h20, '0, 16'h0, 1'b1);
    cycle(3'd0, 32'h0, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_data !== D30) begin
      n_errors++; $display("FAIL stall_write: got %h expected %h", s_data, D30);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] a, b;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    cycle(3'd1, 32'h00, a, 16'hFFFF, 1'b1);
    cycle(3'd1, 32'h10, b, 16'hFFFF, 1'b1);
    cycle(3'd2, 32'h00, '0, 16'h0, 1'b1);
    cycle(3'd2, 32'h10, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_acc !== 1'b1 || s_resp !== 2'd1 || s_data !== a) begin
      n_errors++; $display("FAIL b2b_0: got %b/%0d/%h expected 1/1/%h", s_acc, s_resp, s_data, a);
    end
    cycle(3'd2, 32'h20, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_acc !== 1'b1 || s_resp !== 2'd1 || s_data !== b) begin
      n_errors++; $display("FAIL b2b_1: got %b/%0d/%h expected 1/1/%h", s_acc, s_resp, s_data, b);
    end
    cycle(3'd0, 32'h0, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_resp !== 2'd1 || s_data !== D30) begin
      n_errors++; $display("FAIL b2b_2: got %0d/%h expected 1/%h", s_resp, s_data, D30);
    end
  endtask

  task automatic test_random;
    logic [2:0]  cmd;
    logic [31:0] addr;
    int v;
    for (int n = 0; n < 400; n++) begin
      v = $urandom_range(0, 9);
      cmd = (v < 4) ? 3'd1 : (v < 7) ? 3'd2 : (v == 8) ? 3'($urandom_range(3, 7)) : 3'd0;
      addr = ($urandom_range(0, 9) == 0) ? $urandom : {24'h0, 4'($urandom), 4'($urandom)};
      cycle(cmd, addr, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
            1'($urandom_range(0, 3) != 0));
      n_checks++;
      if (s_acc !== e_acc) begin
        n_errors++; $display("FAIL rand_accept[%0d]: got %b expected %b", n, s_acc, e_acc);
      end
      n_checks++;
      if (s_resp !== e_resp) begin
        n_errors++; $display("FAIL rand_resp[%0d]: got %0d expected %0d", n, s_resp, e_resp);
      end
      n_checks++;
      if ((s_data & e_mask) !== (e_data & e_mask)) begin
        n_errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, s_data & e_mask, e_data & e_mask);
      end
    end
    cycle(3'd0, 32'h0, '0, 16'h0, 1'b1);
  endtask

  task automatic test_reset_in_resp;
    logic [127:0] c;
    c = {$urandom, $urandom, $urandom, $urandom};
    cycle(3'd1, 32'h30, c, 16'hFFFF, 1'b1);
    cycle(3'd1, 32'h40, ONES, 16'hFFFF, 1'b0);
    rst_n = 1'b0;
    m_pending = 1'b0;
    #1;
    n_checks++;
    if (bus.SResp !== 2'd0 || bus.SCmdAccept !== 1'b0 || bus.SData !== '0) begin
      n_errors++;
      $display("FAIL reset_in_resp: got resp=%0d acc=%b data=%h expected 0/0/0", bus.SResp, bus.SCmdAccept, bus.SData);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(3'd2, 32'h30, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_resp !== 2'd0 || s_acc !== 1'b1) begin
      n_errors++; $display("FAIL post_reset_idle: got %0d/%b expected 0/1", s_resp, s_acc);
    end
    cycle(3'd2, 32'h20, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_data !== c) begin
      n_errors++; $display("FAIL post_reset_data30: got %h expected %h", s_data, c);
    end
    cycle(3'd0, 32'h0, '0, 16'h0, 1'b1);
    n_checks++;
    if (s_data !== D30) begin
      n_errors++; $display("FAIL post_reset_data20: got %h expected %h", s_data, D30);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_mem[i]   = '0;
      m_valid[i] = '0;
    end
    test_reset();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_in_resp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
